addr_routed_interconnect: RTL and testbench

Parametrised address-routed message hub between the control SPI minion adapter and up to 2^ADDR_BITS on-chip endpoints (crossbar controls, SPI master config, FFT input, deserializer reset, and so on). Downstream, it decodes the address field of each tagged message and buffers the payload in a per-port FIFO. Upstream, it merges endpoint responses with a round-robin arbiter and re-tags each with its source address. Compared with the earlier fixed-priority, unbuffered scheme, it adds elastic per-port buffering, fair arbitration, unmapped-address accounting and an optional error response.

---
 rtl/interconnect_pkg.sv | 25 ++
 rtl/addr_routed_interconnect_if.sv | 35 +++
 rtl/interconnect_fifo.sv | 60 ++++++
 rtl/addr_routed_interconnect.sv | 144 ++++++++++++++
 tb/tb_addr_routed_interconnect.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/interconnect_pkg.sv
// Shared definitions for addr_routed_interconnect: sizing, tagged message type,
// requester count (N_PORTS, plus one when INTERCONNECT_ERR_RESP_EN adds the error source).
package interconnect_pkg;
  localparam int BIT_WIDTH  = 32;
  localparam int ADDR_BITS  = 4;
  localparam int N_PORTS    = 10;
  localparam int FIFO_DEPTH = 2;
  localparam int MSG_W      = ADDR_BITS + BIT_WIDTH;

`ifdef INTERCONNECT_ERR_RESP_EN
  localparam int NREQ = N_PORTS + 1;
`else
  localparam int NREQ = N_PORTS;
`endif
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [BIT_WIDTH-1:0] payload;
  } tagged_msg_t;

  function automatic logic [ADDR_BITS-1:0] msg_addr(input logic [MSG_W-1:0] m);
    return m[MSG_W-1 -: ADDR_BITS];
  endfunction
endpackage

// File: rtl/addr_routed_interconnect_if.sv
// Bus bundle for addr_routed_interconnect. Every channel is valid/ready: a transfer
// happens on a rising edge where val && rdy; val never depends combinationally on rdy.
interface addr_routed_interconnect_if;
  import interconnect_pkg::*;

  logic                 up_recv_val;
  logic                 up_recv_rdy;
  tagged_msg_t          up_recv_msg;
  logic                 up_send_val;
  logic                 up_send_rdy;
  tagged_msg_t          up_send_msg;
  logic [N_PORTS-1:0]   dn_send_val;
  logic [N_PORTS-1:0]   dn_send_rdy;
  logic [BIT_WIDTH-1:0] dn_send_msg [N_PORTS];
  logic [N_PORTS-1:0]   dn_recv_val;
  logic [N_PORTS-1:0]   dn_recv_rdy;
  logic [BIT_WIDTH-1:0] dn_recv_msg [N_PORTS];
  logic [15:0]          drop_count;

  modport slave (
    input  up_recv_val, up_recv_msg, output up_recv_rdy,
    output up_send_val, up_send_msg, input  up_send_rdy,
    output dn_send_val, dn_send_msg, input  dn_send_rdy,
    input  dn_recv_val, dn_recv_msg, output dn_recv_rdy,
    output drop_count
  );

  modport master (
    output up_recv_val, up_recv_msg, input  up_recv_rdy,
    input  up_send_val, up_send_msg, output up_send_rdy,
    input  dn_send_val, dn_send_msg, output dn_send_rdy,
    output dn_recv_val, dn_recv_msg, input  dn_recv_rdy,
    input  drop_count
  );
endinterface

// File: rtl/interconnect_fifo.sv
// Valid/ready FIFO. Full blocks pushes even when a pop happens in the same cycle,
// so there is no combinational path from out_rdy to in_rdy.
module interconnect_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push, pop;

  assign in_rdy   = (count_q != (AW+1)'(DEPTH));
  assign out_val  = (count_q != '0);
  assign out_data = mem_q[rd_ptr_q];
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/addr_routed_interconnect.sv
// Address-routed hub: per-endpoint downstream FIFOs, round-robin upstream merge,
// saturating unmapped-address counter. INTERCONNECT_ERR_RESP_EN adds an error response.
module addr_routed_interconnect
  import interconnect_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  addr_routed_interconnect_if.slave  bus
);
  logic [ADDR_BITS-1:0] in_addr;
  logic                 mapped, route_rdy, unmapped_rdy, up_fire, drop_fire;
  logic [N_PORTS-1:0]   fifo_in_val, fifo_in_rdy;
  logic [NREQ-1:0]      req;
  logic [PTR_W-1:0]     ptr_q, ptr_d, grant, idx;
  logic                 grant_found, load, take;
  logic                 out_val_q, out_val_d;
  tagged_msg_t          out_msg_q, out_msg_d;
  logic [15:0]          drop_count_q, drop_count_d;

  assign in_addr = msg_addr(bus.up_recv_msg);
  assign mapped  = int'(in_addr) < N_PORTS;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign fifo_in_val[g] = reset && bus.up_recv_val && mapped && (int'(in_addr) == g);
    interconnect_fifo #(.W(BIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .in_val   (fifo_in_val[g]),
      .in_rdy   (fifo_in_rdy[g]),
      .in_data  (bus.up_recv_msg.payload),
      .out_val  (bus.dn_send_val[g]),
      .out_rdy  (bus.dn_send_rdy[g]),
      .out_data (bus.dn_send_msg[g])
    );
  end

`ifdef INTERCONNECT_ERR_RESP_EN
  logic                 err_val_q, err_val_d;
  logic [ADDR_BITS-1:0] err_addr_q, err_addr_d;
  assign unmapped_rdy = !err_val_q;
  assign req          = {err_val_q, bus.dn_recv_val};
`else
  assign unmapped_rdy = 1'b1;
  assign req          = bus.dn_recv_val;
`endif

  always_comb begin
    route_rdy = unmapped_rdy;
    for (int i = 0; i < N_PORTS; i++) begin
      if (mapped && int'(in_addr) == i) route_rdy = fifo_in_rdy[i];
    end
    bus.up_recv_rdy = reset && route_rdy;
  end

  assign up_fire   = bus.up_recv_val && bus.up_recv_rdy;
  assign drop_fire = up_fire && !mapped;

  // First requester at or after ptr_q, searching circularly.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!grant_found && req[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  assign load = reset && (!out_val_q || bus.up_send_rdy);
  assign take = load && grant_found;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) bus.dn_recv_rdy[i] = take && (int'(grant) == i);
  end

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    ptr_d     = ptr_q;
    if (load) out_val_d = grant_found;
    if (take) begin
      out_msg_d.addr    = ADDR_BITS'(grant);
      out_msg_d.payload = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        if (int'(grant) == i) out_msg_d.payload = bus.dn_recv_msg[i];
      end
`ifdef INTERCONNECT_ERR_RESP_EN
      if (int'(grant) == N_PORTS) begin
        out_msg_d.addr    = err_addr_q;
        out_msg_d.payload = '1;
      end
`endif
      ptr_d = (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_fire && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

`ifdef INTERCONNECT_ERR_RESP_EN
  always_comb begin
    err_val_d  = err_val_q;
    err_addr_d = err_addr_q;
    if (take && int'(grant) == N_PORTS) err_val_d = 1'b0;
    if (drop_fire) begin
      err_val_d  = 1'b1;
      err_addr_d = in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_val_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_val_q  <= err_val_d;
      err_addr_q <= err_addr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_val_q    <= 1'b0;
      out_msg_q    <= '0;
      ptr_q        <= '0;
      drop_count_q <= '0;
    end else begin
      out_val_q    <= out_val_d;
      out_msg_q    <= out_msg_d;
      ptr_q        <= ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.up_send_val = out_val_q;
  assign bus.up_send_msg = out_msg_q;
  assign bus.drop_count  = drop_count_q;
endmodule

// File: tb/tb_addr_routed_interconnect.sv
// Bench for addr_routed_interconnect: vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_addr_routed_interconnect;
  import interconnect_pkg::*;

`ifdef INTERCONNECT_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  addr_routed_interconnect_if bus ();
  addr_routed_interconnect dut (.clk(clk), .reset(reset), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    bus.up_recv_val = 1'b0;
    bus.up_recv_msg = '0;
    bus.up_send_rdy = 1'b1;
    bus.dn_send_rdy = '1;
    bus.dn_recv_val = '0;
    for (int i = 0; i < N_PORTS; i++) bus.dn_recv_msg[i] = '0;
  endtask

  task automatic send(input logic [ADDR_BITS-1:0] a, input logic [BIT_WIDTH-1:0] p);
    bus.up_recv_val = 1'b1;
    bus.up_recv_msg = {a, p};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [BIT_WIDTH-1:0] payload;
    logic [N_PORTS-1:0]   exp_val;
    logic [15:0]          exp_drop;
    logic                 exp_err;
  } vec_t;
  vec_t tbl [6];

  // Reference model state
  logic [BIT_WIDTH-1:0] mq [N_PORTS][$];
  int                   m_drop;
  logic                 m_oval;
  logic [MSG_W-1:0]     m_omsg;
  int                   m_ptr;
  logic                 m_err_v;
  logic [ADDR_BITS-1:0] m_err_a;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N_PORTS-1:0] exp_v;
    int order [3];
    order[0] = 2; order[1] = 5; order[2] = 9;

    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    bus.dn_recv_val = '1;
    bus.up_recv_val = 1'b1;
    #1;
    chk("rst_up_recv_rdy", bus.up_recv_rdy, 0);
    chk("rst_dn_recv_rdy", bus.dn_recv_rdy, 0);
    chk("rst_up_send_val", bus.up_send_val, 0);
    chk("rst_dn_send_val", bus.dn_send_val, 0);
    chk("rst_drop_count", bus.drop_count, 0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_rst_up_recv_rdy", bus.up_recv_rdy, 1);
    chk("post_rst_up_send_val", bus.up_send_val, 0);
    @(negedge clk);

    // ---------------- table-driven routing ----------------
    tbl[0] = '{4'd3,  32'h0000_1234, N_PORTS'(1) << 3, 16'd0, 1'b0};
    tbl[1] = '{4'd0,  32'hDEAD_BEEF, N_PORTS'(1) << 0, 16'd0, 1'b0};
    tbl[2] = '{4'd9,  32'h0F0F_0000, N_PORTS'(1) << 9, 16'd0, 1'b0};
    tbl[3] = '{4'd12, 32'h0000_CAFE, '0,               16'd1, ERR_EN};
    tbl[4] = '{4'd15, 32'h0000_5555, '0,               16'd2, ERR_EN};
    tbl[5] = '{4'd5,  32'hA5A5_A5A5, N_PORTS'(1) << 5, 16'd2, 1'b0};
    for (int v = 0; v < 6; v++) begin
      send(tbl[v].addr, tbl[v].payload);
      #1;
      chk("tbl_up_recv_rdy", bus.up_recv_rdy, 1);
      @(negedge clk);
      bus.up_recv_val = 1'b0;
      chk("tbl_dn_send_val", bus.dn_send_val, tbl[v].exp_val);
      if (tbl[v].exp_val != '0) chk("tbl_dn_send_msg", bus.dn_send_msg[tbl[v].addr], tbl[v].payload);
      chk("tbl_drop_count", bus.drop_count, tbl[v].exp_drop);
      @(negedge clk);
      chk("tbl_dn_drained", bus.dn_send_val, 0);
      chk("tbl_err_val", bus.up_send_val, tbl[v].exp_err);
      if (tbl[v].exp_err) chk("tbl_err_msg", bus.up_send_msg, {tbl[v].addr, 32'hFFFF_FFFF});
    end
    @(negedge clk);

    // ---------------- back-pressure on port 1 ----------------
    bus.dn_send_rdy[1] = 1'b0;
    send(4'd1, 32'h1111_000A);
    #1; chk("bp_rdy_a", bus.up_recv_rdy, 1);
    @(negedge clk);
    send(4'd1, 32'h1111_000B);
    #1; chk("bp_rdy_b", bus.up_recv_rdy, 1);
    @(negedge clk);
    send(4'd1, 32'h1111_000C);
    #1; chk("bp_stall_c", bus.up_recv_rdy, 0);
    chk("bp_head_a", bus.dn_send_msg[1], 32'h1111_000A);
    @(negedge clk);
    #1; chk("bp_stall_hold", bus.up_recv_rdy, 0);
    bus.dn_send_rdy[1] = 1'b1;
    #1; chk("bp_no_passthru", bus.up_recv_rdy, 0);
    @(negedge clk);
    #1; chk("bp_reopen", bus.up_recv_rdy, 1);
    chk("bp_head_b", bus.dn_send_msg[1], 32'h1111_000B);
    @(negedge clk);
    bus.up_recv_val = 1'b0;
    chk("bp_val_c", bus.dn_send_val[1], 1);
    chk("bp_head_c", bus.dn_send_msg[1], 32'h1111_000C);
    @(negedge clk);
    chk("bp_empty", bus.dn_send_val, 0);

    // ---------------- round-robin fairness ----------------
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      bus.dn_recv_msg[order[k]] = 32'hA000_0000 + 32'(order[k]);
      bus.dn_recv_val[order[k]] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_val", bus.up_send_val, 1);
      chk("rr_msg", bus.up_send_msg,
          {ADDR_BITS'(order[k % 3]), 32'hA000_0000 + 32'(order[k % 3])});
    end
    bus.dn_recv_val = '0;

    // ---------------- reset mid-stream ----------------
    bus.dn_send_rdy = '0;
    send(4'd4, 32'h4444_4444);
    @(negedge clk);
    send(4'd7, 32'h7777_7777);
    @(negedge clk);
    send(4'd12, 32'h0000_0012);
    @(negedge clk);
    bus.up_recv_val = 1'b0;
    chk("mid_pre_val", bus.dn_send_val, (N_PORTS'(1) << 4) | (N_PORTS'(1) << 7));
    chk("mid_pre_drop", bus.drop_count, 1);
    reset = 1'b0;
    bus.dn_recv_val[0] = 1'b1; bus.dn_recv_msg[0] = 32'h0000_00A0;
    bus.dn_recv_val[8] = 1'b1; bus.dn_recv_msg[8] = 32'h0000_00A8;
    #1;
    chk("mid_rst_up_rdy", bus.up_recv_rdy, 0);
    chk("mid_rst_dn_rdy", bus.dn_recv_rdy, 0);
    @(negedge clk);
    chk("mid_rst_dn_val", bus.dn_send_val, 0);
    chk("mid_rst_up_val", bus.up_send_val, 0);
    chk("mid_rst_drop", bus.drop_count, 0);
    reset = 1'b1;
    bus.dn_send_rdy = '1;
    #1;
    chk("mid_rel_up_rdy", bus.up_recv_rdy, 1);
    @(negedge clk);
    chk("mid_rel_stale", bus.dn_send_val, 0);
    chk("mid_rel_ptr0", bus.up_send_msg, {4'd0, 32'h0000_00A0});
    bus.dn_recv_val = '0;

    // ---------------- randomized run against the model ----------------
    apply_reset();
    for (int i = 0; i < N_PORTS; i++) mq[i].delete();
    m_drop = 0; m_oval = 1'b0; m_omsg = '0; m_ptr = 0; m_err_v = 1'b0; m_err_a = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g, clr, a;
      logic exp_rdy, load, fire;
      logic [N_PORTS-1:0] exp_rr;
      logic [BIT_WIDTH-1:0] p;

      for (int i = 0; i < N_PORTS; i++) exp_v[i] = (mq[i].size() > 0);
      chk("rnd_dn_val", bus.dn_send_val, exp_v);
      for (int i = 0; i < N_PORTS; i++)
        if (exp_v[i]) chk("rnd_dn_msg", bus.dn_send_msg[i], mq[i][0]);
      chk("rnd_up_val", bus.up_send_val, m_oval);
      if (m_oval) chk("rnd_up_msg", bus.up_send_msg, m_omsg);
      chk("rnd_drop", bus.drop_count, m_drop);

      a = $urandom_range(0, 15);
      p = $urandom;
      bus.up_recv_val = ($urandom_range(0, 3) != 0);
      bus.up_recv_msg = {ADDR_BITS'(a), p};
      bus.dn_send_rdy = N_PORTS'($urandom);
      bus.up_send_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_PORTS; i++) begin
        if (!bus.dn_recv_val[i] && $urandom_range(0, 3) == 0) begin
          bus.dn_recv_val[i] = 1'b1;
          bus.dn_recv_msg[i] = $urandom;
        end
      end
      #1;

      if (a < N_PORTS) exp_rdy = (mq[a].size() < FIFO_DEPTH);
      else             exp_rdy = ERR_EN ? !m_err_v : 1'b1;
      chk("rnd_up_recv_rdy", bus.up_recv_rdy, exp_rdy);

      load = !m_oval || bus.up_send_rdy;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (m_ptr + k) % NREQ;
        if (g < 0 && ((r < N_PORTS) ? bus.dn_recv_val[r] : m_err_v)) g = r;
      end
      exp_rr = '0;
      if (load && g >= 0 && g < N_PORTS) exp_rr[g] = 1'b1;
      chk("rnd_dn_recv_rdy", bus.dn_recv_rdy, exp_rr);

      fire = bus.up_recv_val && exp_rdy;
      for (int i = 0; i < N_PORTS; i++)
        if (mq[i].size() > 0 && bus.dn_send_rdy[i]) void'(mq[i].pop_front());
      clr = -1;
      if (load) begin
        if (g >= 0) begin
          m_oval = 1'b1;
          if (g < N_PORTS) begin
            m_omsg = {ADDR_BITS'(g), bus.dn_recv_msg[g]};
            clr = g;
          end else begin
            m_omsg  = {m_err_a, {BIT_WIDTH{1'b1}}};
            m_err_v = 1'b0;
          end
          m_ptr = (g + 1) % NREQ;
        end else begin
          m_oval = 1'b0;
        end
      end
      if (fire) begin
        if (a < N_PORTS) mq[a].push_back(p);
        else begin
          if (m_drop < 16'hFFFF) m_drop++;
          if (ERR_EN) begin
            m_err_v = 1'b1;
            m_err_a = ADDR_BITS'(a);
          end
        end
      end
      @(negedge clk);
      if (clr >= 0) bus.dn_recv_val[clr] = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
